// File: rtl/mini_mips_pkg.sv
// Shared Mini-MIPS definitions: requester encoding, arbiter states and
// default memory geometry.
package mini_mips_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_LDR = 1'b1
  } owner_e;

  typedef enum logic {
    ARB_IDLE_RR,
    ARB_LOCK
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: under contention the port that did not own
// the last grant wins. Purely combinational, one-hot or zero output.
module rr_arb2
  import mini_mips_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  owner_e last_owner,
  output logic   gnt0,
  output logic   gnt1
);

  assign gnt0 = req0 & (~req1 | (last_owner == OWNER_LDR));
  assign gnt1 = req1 & ~gnt0;

endmodule

// File: rtl/mini_mips_dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store stage and
// the loader/debug port, with round-robin contention and bounded lock bursts.
module mini_mips_dmem_arbiter
  import mini_mips_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  // cnt == CNT_LAST is the same test as cnt + 1 == MAX_BURST without widening.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e       state;
  owner_e           last_owner;
  logic [CNT_W-1:0] cnt;
  logic             rr_cpu;
  logic             rr_ldr;

  rr_arb2 u_rr_arb2 (
    .req0       (cpu_req),
    .req1       (ldr_req),
    .last_owner (last_owner),
    .gnt0       (rr_cpu),
    .gnt1       (rr_ldr)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    if (rst_n) begin
      if (state == ARB_LOCK) begin
        ldr_gnt = ldr_req;
      end else begin
        cpu_gnt = rr_cpu;
        ldr_gnt = rr_ldr;
      end
    end
  end

  assign mem_en    = cpu_gnt | ldr_gnt;
  assign mem_we    = cpu_gnt ? cpu_we    : (ldr_gnt ? ldr_we    : 1'b0);
  assign mem_addr  = cpu_gnt ? cpu_addr  : (ldr_gnt ? ldr_addr  : '0);
  assign mem_wdata = cpu_gnt ? cpu_wdata : (ldr_gnt ? ldr_wdata : '0);

  // Both ports see the memory output; only the strobes say whose read it was.
  assign cpu_rdata = mem_rdata;
  assign ldr_rdata = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE_RR;
      last_owner <= OWNER_LDR;
      cnt        <= '0;
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      ldr_rvalid <= ldr_gnt & ~ldr_we;
      case (state)
        ARB_IDLE_RR: begin
          if (cpu_gnt) begin
            last_owner <= OWNER_CPU;
          end else if (ldr_gnt) begin
            last_owner <= OWNER_LDR;
            if (ldr_lock) begin
              state <= ARB_LOCK;
              cnt   <= CNT_W'(1);
            end
          end
        end
        ARB_LOCK: begin
          // Idle lock cycles still burn budget, bounding the CPU stall.
          last_owner <= OWNER_LDR;
          cnt        <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST || !ldr_lock) state <= ARB_IDLE_RR;
        end
        default: state <= ARB_IDLE_RR;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_mips_dmem_arbiter.sv
// Self-checking bench: directed grant sequences plus a read-data scoreboard
// fed from a behavioural 1-cycle-latency memory.
module tb_mini_mips_dmem_arbiter;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_rvalid;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata, ldr_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] mem    [2**ADDR_W];
  logic [DATA_W-1:0] shadow [2**ADDR_W];
  logic [DATA_W-1:0] q_cpu[$];
  logic [DATA_W-1:0] q_ldr[$];
  logic              pend_cpu = 1'b0;
  logic              pend_ldr = 1'b0;

  always #5 clk = ~clk;

  mini_mips_dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural memory with registered read data.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Scoreboard and structural monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
      check("rst_ldr_rvalid", {31'b0, ldr_rvalid}, 32'd0);
      check("rst_mem_en", {31'b0, mem_en}, 32'd0);
      pend_cpu = 1'b0;
      pend_ldr = 1'b0;
      q_cpu.delete();
      q_ldr.delete();
    end else begin
      logic [DATA_W-1:0] exp_data;
      check("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, pend_cpu});
      if (pend_cpu) begin
        exp_data = q_cpu.pop_front();
        if (cpu_rvalid) check("cpu_rdata", cpu_rdata, exp_data);
      end
      check("ldr_rvalid", {31'b0, ldr_rvalid}, {31'b0, pend_ldr});
      if (pend_ldr) begin
        exp_data = q_ldr.pop_front();
        if (ldr_rvalid) check("ldr_rdata", ldr_rdata, exp_data);
      end
      check("one_gnt", {31'b0, cpu_gnt & ldr_gnt}, 32'd0);
      check("mem_en", {31'b0, mem_en}, {31'b0, cpu_gnt | ldr_gnt});
      if (cpu_gnt) begin
        check("mem_addr_cpu", {24'b0, mem_addr}, {24'b0, cpu_addr});
        check("mem_we_cpu", {31'b0, mem_we}, {31'b0, cpu_we});
      end else if (ldr_gnt) begin
        check("mem_addr_ldr", {24'b0, mem_addr}, {24'b0, ldr_addr});
        check("mem_we_ldr", {31'b0, mem_we}, {31'b0, ldr_we});
      end else begin
        check("mem_idle", {23'b0, mem_we, mem_addr}, 32'd0);
      end
      pend_cpu = cpu_gnt & ~cpu_we;
      pend_ldr = ldr_gnt & ~ldr_we;
      if (pend_cpu) q_cpu.push_back(shadow[cpu_addr]);
      if (pend_ldr) q_ldr.push_back(shadow[ldr_addr]);
      if (cpu_gnt && cpu_we) shadow[cpu_addr] = cpu_wdata;
      if (ldr_gnt && ldr_we) shadow[ldr_addr] = ldr_wdata;
    end
  end

  task automatic drive(input logic cr, input logic cw, input logic [7:0] ca,
                       input logic [31:0] cd, input logic lr, input logic lw,
                       input logic [7:0] la, input logic [31:0] ld, input logic lk);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld; ldr_lock = lk;
  endtask

  // Check grants for the current cycle, then advance to just after the next edge.
  task automatic step(input string tag, input logic ec, input logic el);
    @(negedge clk);
    check({tag, "_cpu_gnt"}, {31'b0, cpu_gnt}, {31'b0, ec});
    check({tag, "_ldr_gnt"}, {31'b0, ldr_gnt}, {31'b0, el});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) begin
      mem[i]    = 32'hA500_0000 | i;
      shadow[i] = 32'hA500_0000 | i;
    end
    mem[5]    = 32'hDEAD_BEEF;
    shadow[5] = 32'hDEAD_BEEF;
    mem_rdata = '0;
    rst_n = 1'b0;
    drive(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    step("in_reset", 0, 0);

    // Single CPU read after reset.
    do_reset();
    drive(1, 0, 8'h05, 0, 0, 0, 8'h00, 0, 0);
    step("cpu_read", 1, 0);
    drive(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    @(negedge clk);
    check("single_rvalid", {31'b0, cpu_rvalid}, 32'd1);
    check("single_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("single_ldr_rvalid", {31'b0, ldr_rvalid}, 32'd0);
    @(posedge clk); #1;

    // Continuous contention alternates, CPU first.
    do_reset();
    drive(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 0);
    for (int i = 0; i < 6; i++) step("rr", (i % 2) == 0, (i % 2) == 1);

    // Lock bound: loader holds 4 cycles, then the CPU gets in.
    do_reset();
    drive(1, 0, 8'h03, 0, 1, 0, 8'h04, 0, 1);
    step("lock_c0", 1, 0);
    for (int i = 0; i < MAX_BURST; i++) step("lock_l", 0, 1);
    step("lock_c1", 1, 0);

    // Idle lock cycles still count toward the bound.
    do_reset();
    drive(0, 0, 8'h00, 0, 1, 0, 8'h06, 0, 1);
    step("idle_lock_l", 0, 1);
    drive(1, 0, 8'h07, 0, 0, 0, 8'h06, 0, 1);
    for (int i = 1; i < MAX_BURST; i++) step("idle_lock_none", 0, 0);
    step("idle_lock_c", 1, 0);

    // Early unlock in the second lock cycle.
    do_reset();
    drive(1, 0, 8'h08, 0, 1, 0, 8'h09, 0, 1);
    step("early_c0", 1, 0);
    step("early_l0", 0, 1);
    ldr_lock = 1'b0;
    step("early_l1", 0, 1);
    step("early_c1", 1, 0);

    // Loader write followed by CPU read of the same word.
    drive(0, 0, 8'h00, 0, 1, 1, 8'h10, 32'h1234_5678, 0);
    step("wr_l", 0, 1);
    drive(1, 0, 8'h10, 0, 0, 0, 8'h00, 0, 0);
    step("rd_c", 1, 0);
    drive(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    @(negedge clk);
    check("raw_rvalid", {31'b0, cpu_rvalid}, 32'd1);
    check("raw_rdata", cpu_rdata, 32'h1234_5678);
    @(posedge clk); #1;

    // Reset the cycle after a granted read drops the response.
    drive(1, 0, 8'h05, 0, 0, 0, 8'h00, 0, 0);
    step("pre_rst_c", 1, 0);
    rst_n = 1'b0;
    drive(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 1);
    @(negedge clk);
    check("midrst_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    check("midrst_gnt", {30'b0, cpu_gnt, ldr_gnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_rst_c", 1, 0);
    step("post_rst_l", 0, 1);

    drive(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mini_mips_dmem_arbiter.md
# mini_mips_dmem_arbiter

Shares the Mini-MIPS single-port data memory between two requesters: the processor's load/store stage (CPU port) and a loader/debug port used to preload or inspect memory contents. Each cycle it grants at most one access, issues it to the memory, and returns read data one cycle later with a per-port valid strobe. Contention is round-robin. The loader may lock the memory for a bounded burst.

## Interface
Parameters:
- ADDR_W, 8, data-memory word address width
- DATA_W, 32, data word width
- MAX_BURST, 4, maximum cycles of one loader lock window (≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle (combinational)
- cpu_rvalid  out  1  CPU read data valid (registered)
- cpu_rdata  out  DATA_W  read data to CPU
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/DATA_W  loader request, same meaning as the CPU fields
- ldr_lock  in  1  loader requests exclusive ownership
- ldr_gnt, ldr_rvalid, ldr_rdata  out  1/1/DATA_W  loader grant and response
- mem_en, mem_we  out  1/1  memory strobe and write enable
- mem_addr, mem_wdata  out  ADDR_W/DATA_W  memory address and write data
- mem_rdata  in  DATA_W  memory read data, registered by the memory (1-cycle latency)

## Operation
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt high. A transfer happens in any cycle where req & gnt are both high.
  - The CPU treats cpu_req & ~cpu_gnt as a stall.
- Grants:
  - At most one gnt is high per cycle.
  - mem_en = cpu_gnt | ldr_gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the granted port. They are 0 when nothing is granted.
- FSM state ARB:
  - If only one port requests, that port is granted.
  - If both request, grant the port that is not last_owner.
  - On every grant, last_owner takes the value of the granted port.
  - If the loader is granted with ldr_lock=1, the next state is LOCK and cnt is set to 1.
- FSM state LOCK:
  - cpu_gnt is 0. ldr_gnt = ldr_req.
  - At every edge, cnt increments by 1.
  - Go to ARB when (cnt+1 == MAX_BURST) or ldr_lock == 0. On exit, last_owner = loader, so the CPU wins the next contended cycle.
  - Every cycle in LOCK counts toward MAX_BURST, whether or not the loader requests. The CPU can never be blocked for more than MAX_BURST consecutive cycles by a lock.
- Responses:
  - A granted read (we=0) sets that port's rvalid high for exactly the next cycle.
  - Writes produce no rvalid.
  - cpu_rdata and ldr_rdata both carry mem_rdata directly. Only the rvalid strobes differ.
- Ordering: a read granted the cycle after a write to the same address returns the new data. Per-port order is preserved because there is exactly one access per cycle.
- Width rules:
  - cnt is $clog2(MAX_BURST+1) bits.
  - No arithmetic is done on the data path.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=ARB, last_owner=loader (the CPU wins the first contention), cnt=0.
  - cpu_rvalid=ldr_rvalid=0.
  - While rst_n=0, cpu_gnt, ldr_gnt and mem_en are forced to 0.
- Grant latency: 0 cycles, since gnt depends combinationally on req and the state.
- Read latency: rvalid and rdata arrive 1 cycle after gnt. Throughput is one access per cycle.
- Reset mid-operation: a pending rvalid is dropped, and any lock window is cancelled.
- ldr_lock high while the loader is not granted in ARB has no effect.

## Structure
- The shared package mini_mips_pkg holds:
  - owner encoding: OWNER_CPU=1'b0, OWNER_LDR=1'b1
  - arbiter state enum: ARB_IDLE_RR, ARB_LOCK
  - default ADDR_W and DATA_W
- One sub-module is natural: rr_arb2, a combinational 2-way round-robin picker taking (req0, req1, last_owner) and producing the one-hot grant. The FSM, counter and rvalid registers stay in the top module.

## Test plan
- Single CPU read after reset: cpu_req=1, we=0, addr=8'h05 (memory holds 32'hDEADBEEF) -> cpu_gnt=1 in the same cycle; next cycle cpu_rvalid=1 and cpu_rdata=32'hDEADBEEF; ldr_rvalid stays 0.
- Contention: both ports request reads every cycle from the first cycle after reset -> grants alternate CPU, LDR, CPU, LDR; mem_addr alternates accordingly; never two gnt high in one cycle.
- Lock bound: MAX_BURST=4, both request continuously, ldr_lock=1 -> loader granted 4 consecutive cycles, CPU granted on the 5th; cpu stall lasts exactly 4 cycles.
- Early unlock: loader locks, then drops ldr_lock in the 2nd lock cycle -> return to ARB after that cycle; the contended cycle that follows grants the CPU.
- Write-then-read: loader writes 32'h12345678 to 8'h10, CPU reads 8'h10 in the next cycle -> cpu_rdata=32'h12345678 with cpu_rvalid one cycle after the CPU grant.
- Reset mid-read: assert rst_n=0 in the cycle after a granted read -> rvalid=0 immediately and all grants 0; after release, the CPU wins the first contended cycle.
